mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter READ_LATENCY, default 1, legal range 1..4: number of clock edges from the data-memory address being driven to mem_rdata being sampled.
REQ-002 Parameter OP_LD, default 4'h8: execute-op code for a load.
REQ-003 Parameter OP_ST, default 4'h9: execute-op code for a store.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 CPU_RESET_n  input  1  reset, asynchronous and active-low.
REQ-006 x_op  input  4  op from execute stage (ADD 4'h0, NOP 4'h2, BRZ 4'h5, SUB 4'hf, OP_LD, OP_ST).
REQ-007 x_dest  input  3  destination register.
REQ-008 x_value  input  16  ALU result for ADD/SUB; effective address for LD/ST.
REQ-009 x_store_data  input  16  store data for ST.
REQ-010 mem_rdata  input  16  data-memory read data.
REQ-011 mem_addr  output  16  data-memory address, registered.
REQ-012 mem_wdata  output  16  data-memory write data, registered.
REQ-013 mem_wren  output  1  data-memory write enable, registered, one-cycle pulse per store.
REQ-014 stall  output  1  upstream must hold x_* stable and not advance while high.
REQ-015 wb_dest  output  3  writeback register, registered.
REQ-016 wb_value  output  16  writeback value, registered.
REQ-017 wb_enable  output  1  writeback strobe to register file, registered.
REQ-018 retired  output  16  count of retired non-NOP ops.

Function
REQ-019 States: IDLE, LD_WAIT; 3-bit latency counter lat_cnt.
REQ-020 IDLE, x_op=ADD or SUB: at the edge, wb_enable<=1, wb_dest<=x_dest, wb_value<=x_value; stall=0.
REQ-021 wb_enable SHALL be forced 0 for any op whose x_dest=7; wb_dest/wb_value still update.
REQ-022 IDLE, x_op=OP_ST: at the edge, mem_addr<=x_value, mem_wdata<=x_store_data, mem_wren<=1, wb_enable<=0; stall=0.
REQ-023 mem_wren SHALL be 0 on every edge not accepting a store.
REQ-024 IDLE, x_op=NOP, BRZ or any undefined code: wb_enable<=0, no memory access; stall=0.
REQ-025 IDLE, x_op=OP_LD: stall=1 combinationally in that cycle; at the edge, mem_addr<=x_value, lat_cnt<=READ_LATENCY, wb_enable<=0, state<=LD_WAIT.
REQ-026 LD_WAIT, lat_cnt>1: stall=1, lat_cnt decrements at each edge, x_* ignored, wb_enable<=0.
REQ-027 LD_WAIT, lat_cnt=1: stall=0; at the edge, wb_value<=mem_rdata, wb_dest<=x_dest, wb_enable<=1 (subject to REQ-021), state<=IDLE; upstream advances at the same edge.
REQ-028 A load occupies READ_LATENCY+1 cycles with exactly READ_LATENCY stall cycles; the held load SHALL NOT be re-accepted.
REQ-029 Store immediately followed by a load to the same address SHALL return the stored data (write reaches memory before load address is sampled).
REQ-030 retired SHALL increment by 1 on each edge retiring ADD, SUB, BRZ, ST, or completing LD (REQ-027); NOP/undefined do not count; wraps 16'hFFFF -> 16'h0000.
REQ-031 Load-use hazard detection and forwarding are outside this block.

Reset
REQ-032 CPU_RESET_n low SHALL immediately force state=IDLE, lat_cnt=0, mem_addr=0, mem_wdata=0, mem_wren=0, wb_dest=0, wb_value=0, wb_enable=0, retired=0; stall then follows REQ-025 from current x_op.
REQ-033 Reset asserted during LD_WAIT SHALL discard the load with no writeback.
REQ-034 First active edge after deassertion SHALL behave as IDLE.

Verification
REQ-035 ADD x_dest=3 x_value=16'h1234 -> next cycle wb_enable=1, wb_dest=3, wb_value=16'h1234, retired=1, stall never high.
REQ-036 READ_LATENCY=2, LD x_value=16'h0040, memory[0x40]=16'hBEEF -> stall high 2 cycles, mem_addr=16'h0040, then wb_value=16'hBEEF, wb_enable=1 one cycle.
REQ-037 ST x_value=16'h0010 data=16'hA5A5 then LD r2 from 16'h0010 -> mem_wren pulse 1 cycle, then wb_dest=2, wb_value=16'hA5A5.
REQ-038 ADD x_dest=7 -> wb_enable=0, retired increments; NOP -> retired unchanged.
REQ-039 CPU_RESET_n low mid-LD_WAIT -> stall=0 (x_op=NOP), wb_enable=0, no writeback of the load after release.
REQ-040 retired preloaded to 16'hFFFF via 65535 ADDs, one more SUB -> retired=16'h0000.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: retires ALU ops, issues stores, and stalls upstream for loads
// until read data returns READ_LATENCY edges after the address is registered.
module mem_stage #(
    parameter int         READ_LATENCY = 1,
    parameter logic [3:0] OP_LD        = 4'h8,
    parameter logic [3:0] OP_ST        = 4'h9
) (
    input  logic        clk,
    input  logic        CPU_RESET_n,
    input  logic [3:0]  x_op,
    input  logic [2:0]  x_dest,
    input  logic [15:0] x_value,
    input  logic [15:0] x_store_data,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wren,
    output logic        stall,
    output logic [2:0]  wb_dest,
    output logic [15:0] wb_value,
    output logic        wb_enable,
    output logic [15:0] retired
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_BRZ = 4'h5;
    localparam logic [3:0] OP_SUB = 4'hf;

    typedef enum logic {IDLE, LD_WAIT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_lat_cnt;
    logic [2:0]  w_lat_nxt;
    logic        w_wb_upd;
    logic        w_wb_from_mem;
    logic        w_st;
    logic        w_ld_issue;
    logic        w_retire;

    always_comb begin
        w_state_nxt   = r_state;
        w_lat_nxt     = r_lat_cnt;
        stall         = 1'b0;
        w_wb_upd      = 1'b0;
        w_wb_from_mem = 1'b0;
        w_st          = 1'b0;
        w_ld_issue    = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            IDLE: begin
                if (x_op == OP_LD) begin
                    stall       = 1'b1;
                    w_ld_issue  = 1'b1;
                    w_lat_nxt   = 3'(READ_LATENCY);
                    w_state_nxt = LD_WAIT;
                end else if (x_op == OP_ST) begin
                    w_st     = 1'b1;
                    w_retire = 1'b1;
                end else if (x_op == OP_ADD || x_op == OP_SUB) begin
                    w_wb_upd = 1'b1;
                    w_retire = 1'b1;
                end else if (x_op == OP_BRZ) begin
                    w_retire = 1'b1;
                end
            end
            LD_WAIT: begin
                if (r_lat_cnt > 3'd1) begin
                    stall     = 1'b1;
                    w_lat_nxt = r_lat_cnt - 3'd1;
                end else begin
                    // x_* still holds the load, so x_dest is the load's target
                    w_wb_upd      = 1'b1;
                    w_wb_from_mem = 1'b1;
                    w_retire      = 1'b1;
                    w_lat_nxt     = 3'd0;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge CPU_RESET_n) begin
        if (!CPU_RESET_n) begin
            r_state   <= IDLE;
            r_lat_cnt <= 3'd0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            mem_wren  <= 1'b0;
            wb_dest   <= 3'd0;
            wb_value  <= 16'h0000;
            wb_enable <= 1'b0;
            retired   <= 16'h0000;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_nxt;
            mem_wren  <= w_st;
            wb_enable <= w_wb_upd && (x_dest != 3'd7);
            if (w_st || w_ld_issue) begin
                mem_addr <= x_value;
            end
            if (w_st) begin
                mem_wdata <= x_store_data;
            end
            if (w_wb_upd) begin
                wb_dest  <= x_dest;
                wb_value <= w_wb_from_mem ? mem_rdata : x_value;
            end
            if (w_retire) begin
                retired <= retired + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with READ_LATENCY=2 and a registered-read memory model.
module tb_mem_stage;

    logic        clk;
    logic        CPU_RESET_n;
    logic [3:0]  x_op;
    logic [2:0]  x_dest;
    logic [15:0] x_value;
    logic [15:0] x_store_data;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wren;
    logic        stall;
    logic [2:0]  wb_dest;
    logic [15:0] wb_value;
    logic        wb_enable;
    logic [15:0] retired;

    logic [15:0] mem [0:255];
    logic        tb_wr_en;
    logic [7:0]  tb_wr_addr;
    logic [15:0] tb_wr_dat;

    int checks;
    int failures;

    mem_stage #(.READ_LATENCY(2)) dut (
        .clk(clk), .CPU_RESET_n(CPU_RESET_n),
        .x_op(x_op), .x_dest(x_dest), .x_value(x_value), .x_store_data(x_store_data),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .stall(stall), .wb_dest(wb_dest), .wb_value(wb_value),
        .wb_enable(wb_enable), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address registered by DUT, then one more register here: two edges to sample.
    always @(posedge clk) begin
        if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_dat;
        else if (mem_wren) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] d, input logic [15:0] v, input logic [15:0] sd);
        x_op = op; x_dest = d; x_value = v; x_store_data = sd;
    endtask

    initial begin
        checks = 0; failures = 0;
        tb_wr_en = 1'b0; tb_wr_addr = 8'h00; tb_wr_dat = 16'h0000;
        CPU_RESET_n = 1'b0;
        drive(4'h2, 3'd0, 16'h0000, 16'h0000);
        #2;
        check("rst_wb_enable", {31'd0, wb_enable}, 32'd0);
        check("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_wb_value", {16'd0, wb_value}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        check("rst_stall_nop", {31'd0, stall}, 32'd0);
        drive(4'h8, 3'd0, 16'h0000, 16'h0000);
        #1;
        check("rst_stall_ld", {31'd0, stall}, 32'd1);
        drive(4'h2, 3'd0, 16'h0000, 16'h0000);
        tb_wr_en = 1'b1; tb_wr_addr = 8'h40; tb_wr_dat = 16'hBEEF;
        tick();
        tb_wr_en = 1'b0;
        CPU_RESET_n = 1'b1;

        // ADD
        drive(4'h0, 3'd3, 16'h1234, 16'h0000);
        #1;
        check("add_stall", {31'd0, stall}, 32'd0);
        tick();
        check("add_wb_enable", {31'd0, wb_enable}, 32'd1);
        check("add_wb_dest", {29'd0, wb_dest}, 32'd3);
        check("add_wb_value", {16'd0, wb_value}, 32'h1234);
        check("add_retired", {16'd0, retired}, 32'd1);

        // Load with latency 2
        drive(4'h8, 3'd1, 16'h0040, 16'h0000);
        #1;
        check("ld_stall_c0", {31'd0, stall}, 32'd1);
        tick();
        check("ld_mem_addr", {16'd0, mem_addr}, 32'h0040);
        check("ld_stall_c1", {31'd0, stall}, 32'd1);
        check("ld_wb_en_c1", {31'd0, wb_enable}, 32'd0);
        tick();
        check("ld_stall_c2", {31'd0, stall}, 32'd0);
        check("ld_wb_en_c2", {31'd0, wb_enable}, 32'd0);
        tick();
        check("ld_wb_enable", {31'd0, wb_enable}, 32'd1);
        check("ld_wb_value", {16'd0, wb_value}, 32'hBEEF);
        check("ld_wb_dest", {29'd0, wb_dest}, 32'd1);
        check("ld_retired", {16'd0, retired}, 32'd2);
        drive(4'h2, 3'd0, 16'h0000, 16'h0000);
        tick();
        check("ld_wb_en_once", {31'd0, wb_enable}, 32'd0);
        check("ld_no_reaccept", {16'd0, retired}, 32'd2);

        // Store then load same address
        drive(4'h9, 3'd0, 16'h0010, 16'hA5A5);
        #1;
        check("st_stall", {31'd0, stall}, 32'd0);
        tick();
        check("st_mem_wren", {31'd0, mem_wren}, 32'd1);
        check("st_mem_addr", {16'd0, mem_addr}, 32'h0010);
        check("st_mem_wdata", {16'd0, mem_wdata}, 32'hA5A5);
        check("st_wb_enable", {31'd0, wb_enable}, 32'd0);
        check("st_retired", {16'd0, retired}, 32'd3);
        drive(4'h8, 3'd2, 16'h0010, 16'h0000);
        tick();
        check("st_wren_pulse", {31'd0, mem_wren}, 32'd0);
        tick();
        tick();
        check("stld_wb_dest", {29'd0, wb_dest}, 32'd2);
        check("stld_wb_value", {16'd0, wb_value}, 32'hA5A5);
        check("stld_wb_enable", {31'd0, wb_enable}, 32'd1);
        check("stld_retired", {16'd0, retired}, 32'd4);

        // Dest 7 suppression, NOP / BRZ / undefined
        drive(4'h0, 3'd7, 16'h5555, 16'h0000);
        tick();
        check("d7_wb_enable", {31'd0, wb_enable}, 32'd0);
        check("d7_wb_value", {16'd0, wb_value}, 32'h5555);
        check("d7_retired", {16'd0, retired}, 32'd5);
        drive(4'h2, 3'd1, 16'h0000, 16'h0000);
        tick();
        check("nop_retired", {16'd0, retired}, 32'd5);
        drive(4'h5, 3'd1, 16'h0000, 16'h0000);
        tick();
        check("brz_retired", {16'd0, retired}, 32'd6);
        check("brz_wb_enable", {31'd0, wb_enable}, 32'd0);
        drive(4'h3, 3'd1, 16'h0000, 16'h0000);
        tick();
        check("undef_retired", {16'd0, retired}, 32'd6);
        check("undef_wren", {31'd0, mem_wren}, 32'd0);

        // Reset in the middle of a load
        drive(4'h8, 3'd4, 16'h0040, 16'h0000);
        tick();
        CPU_RESET_n = 1'b0;
        drive(4'h2, 3'd0, 16'h0000, 16'h0000);
        #1;
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_wb_en", {31'd0, wb_enable}, 32'd0);
        check("midrst_retired", {16'd0, retired}, 32'd0);
        tick();
        CPU_RESET_n = 1'b1;
        tick();
        check("postrst_wb_en1", {31'd0, wb_enable}, 32'd0);
        check("postrst_stall", {31'd0, stall}, 32'd0);
        tick();
        check("postrst_wb_en2", {31'd0, wb_enable}, 32'd0);
        check("postrst_retired", {16'd0, retired}, 32'd0);

        // Wrap of retired counter
        drive(4'h0, 3'd1, 16'h0001, 16'h0000);
        for (int i = 0; i < 65535; i++) tick();
        check("wrap_preload", {16'd0, retired}, 32'hFFFF);
        drive(4'hf, 3'd5, 16'h00AA, 16'h0000);
        tick();
        check("wrap_retired", {16'd0, retired}, 32'h0000);
        check("wrap_sub_wb", {29'd0, wb_dest}, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
